// File: rtl/qmac_accum.sv
`default_nettype none
// ============================================================================
// Module      : qmac_accum
// Description : Accumulates LEN signed 32-bit products plus a bias, then
//               rounds, shifts, optionally applies ReLU and saturates to N bits.
// Revision    : 1.0 - initial release
// ============================================================================
module qmac_accum #(
    parameter int N          = 8,
    parameter int LEN        = 25,
    parameter int FRAC_SHIFT = 7,
    parameter int RELU       = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ce,
    input  logic                clear,
    input  logic signed [31:0]  product_din,
    input  logic                product_din_vld,
    input  logic signed [31:0]  bias_din,
    output logic        [N-1:0] acc_dout,
    output logic                acc_dout_vld,
    output logic                acc_busy,
    output logic                acc_ovf
);

    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;

    localparam logic [CNT_W-1:0]  c_last    = CNT_W'(LEN - 1);
    localparam logic signed [32:0] c_max_val = (33'sd1 <<< (N - 1)) - 33'sd1;
    localparam logic signed [32:0] c_min_val = -(33'sd1 <<< (N - 1));

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    logic signed [31:0]    r_acc;
    logic [CNT_W-1:0]      r_cnt;
    logic [N-1:0]          r_acc_dout;
    logic                  r_acc_dout_vld;
    logic                  r_acc_ovf;

    logic signed [31:0]    w_add_a;
    logic signed [31:0]    w_add_sum;
    logic                  w_add_ovf;
    logic signed [32:0]    w_round;
    logic signed [32:0]    w_rsum;
    logic signed [32:0]    w_shift;
    logic signed [32:0]    w_relu;
    logic [N-1:0]          w_sat;

    // The first product of a group is added to the bias, later ones to acc.
    assign w_add_a   = (r_cnt == '0) ? bias_din : r_acc;
    assign w_add_sum = w_add_a + product_din;
    assign w_add_ovf = (w_add_a[31] == product_din[31]) && (w_add_sum[31] != w_add_a[31]);

    generate
        if (FRAC_SHIFT > 0) begin : g_round
            assign w_round = 33'sd1 <<< (FRAC_SHIFT - 1);
        end else begin : g_no_round
            assign w_round = 33'sd0;
        end
    endgenerate

    // 33 bits hold acc plus the rounding constant without wrapping.
    assign w_rsum  = {r_acc[31], r_acc} + w_round;
    assign w_shift = w_rsum >>> FRAC_SHIFT;
    assign w_relu  = ((RELU != 0) && w_shift[32]) ? 33'sd0 : w_shift;

    always_comb begin
        w_sat = w_relu[N-1:0];
        if (w_relu > c_max_val) begin
            w_sat = c_max_val[N-1:0];
        end else if (w_relu < c_min_val) begin
            w_sat = c_min_val[N-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_acc          <= '0;
            r_cnt          <= '0;
            r_acc_dout     <= '0;
            r_acc_dout_vld <= 1'b0;
            r_acc_ovf      <= 1'b0;
        end else begin
            r_acc_dout_vld <= 1'b0;
            if (ce) begin
                if (clear) begin
                    r_cnt     <= '0;
                    r_state   <= S_IDLE;
                    r_acc_ovf <= 1'b0;
                end else begin
                    if (r_state == S_DONE) begin
                        r_acc_dout     <= w_sat;
                        r_acc_dout_vld <= 1'b1;
                        r_state        <= S_IDLE;
                    end
                    // A product arriving in S_DONE overrides the state update above.
                    if (product_din_vld) begin
                        r_acc     <= w_add_sum;
                        r_acc_ovf <= (r_cnt == '0) ? w_add_ovf : (r_acc_ovf | w_add_ovf);
                        if (r_cnt == c_last) begin
                            r_cnt   <= '0;
                            r_state <= S_DONE;
                        end else begin
                            r_cnt   <= r_cnt + CNT_W'(1);
                            r_state <= S_ACC;
                        end
                    end
                end
            end
        end
    end

    assign acc_dout     = r_acc_dout;
    assign acc_dout_vld = r_acc_dout_vld;
    assign acc_busy     = (r_cnt != '0);
    assign acc_ovf      = r_acc_ovf;

endmodule
`default_nettype wire

// File: tb/tb_qmac_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_qmac_accum
// Description : Directed bench for qmac_accum, one ReLU and one linear instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qmac_accum;

    logic        clk;
    logic        rst;
    logic        ce;
    logic        clear;
    logic [31:0] product_din;
    logic        product_din_vld;
    logic [31:0] bias_din;

    logic [7:0]  dout_r;
    logic        vld_r;
    logic        busy_r;
    logic        ovf_r;
    logic [7:0]  dout_n;
    logic        vld_n;
    logic        busy_n;
    logic        ovf_n;

    int errors = 0;
    int checks = 0;

    qmac_accum #(.N(8), .LEN(4), .FRAC_SHIFT(2), .RELU(1)) dut (
        .clk(clk), .rst(rst), .ce(ce), .clear(clear),
        .product_din(product_din), .product_din_vld(product_din_vld), .bias_din(bias_din),
        .acc_dout(dout_r), .acc_dout_vld(vld_r), .acc_busy(busy_r), .acc_ovf(ovf_r)
    );

    qmac_accum #(.N(8), .LEN(4), .FRAC_SHIFT(2), .RELU(0)) dut_nr (
        .clk(clk), .rst(rst), .ce(ce), .clear(clear),
        .product_din(product_din), .product_din_vld(product_din_vld), .bias_din(bias_din),
        .acc_dout(dout_n), .acc_dout_vld(vld_n), .acc_busy(busy_n), .acc_ovf(ovf_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] b, input logic [31:0] p);
        bias_din        = b;
        product_din     = p;
        product_din_vld = 1'b1;
        step();
        product_din_vld = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++; if (dout_r !== 8'h00) begin errors++; $display("FAIL reset_dout: got %0h expected 0", dout_r); end
        checks++; if (vld_r !== 1'b0) begin errors++; $display("FAIL reset_vld: got %0b expected 0", vld_r); end
        checks++; if (busy_r !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy_r); end
        checks++; if (ovf_r !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b expected 0", ovf_r); end
    endtask

    task automatic test_basic();
        put(32'd0, 32'd10);
        put(32'd0, 32'd20);
        checks++; if (busy_r !== 1'b1) begin errors++; $display("FAIL basic_busy: got %0b expected 1", busy_r); end
        put(32'd0, 32'd30);
        put(32'd0, 32'd40);
        checks++; if (vld_r !== 1'b0) begin errors++; $display("FAIL basic_vld_early: got %0b expected 0", vld_r); end
        step();
        checks++; if (vld_r !== 1'b1) begin errors++; $display("FAIL basic_vld: got %0b expected 1", vld_r); end
        checks++; if (dout_r !== 8'h19) begin errors++; $display("FAIL basic_dout_relu: got %0h expected 19", dout_r); end
        checks++; if (dout_n !== 8'h19) begin errors++; $display("FAIL basic_dout_lin: got %0h expected 19", dout_n); end
        checks++; if (ovf_r !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %0b expected 0", ovf_r); end
        checks++; if (busy_r !== 1'b0) begin errors++; $display("FAIL basic_busy_done: got %0b expected 0", busy_r); end
        step();
        checks++; if (vld_r !== 1'b0) begin errors++; $display("FAIL basic_vld_pulse: got %0b expected 0", vld_r); end
        checks++; if (dout_r !== 8'h19) begin errors++; $display("FAIL basic_dout_hold: got %0h expected 19", dout_r); end
    endtask

    task automatic test_negative();
        put(32'd0, -32'sd10);
        put(32'd0, -32'sd20);
        put(32'd0, -32'sd30);
        put(32'd0, -32'sd40);
        step();
        checks++; if (vld_n !== 1'b1) begin errors++; $display("FAIL neg_vld: got %0b expected 1", vld_n); end
        checks++; if (dout_r !== 8'h00) begin errors++; $display("FAIL neg_dout_relu: got %0h expected 0", dout_r); end
        checks++; if (dout_n !== 8'hE7) begin errors++; $display("FAIL neg_dout_lin: got %0h expected e7", dout_n); end
        step();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 4; i++) put(32'd0, 32'd1000);
        step();
        checks++; if (dout_r !== 8'h7F) begin errors++; $display("FAIL sat_pos_relu: got %0h expected 7f", dout_r); end
        checks++; if (dout_n !== 8'h7F) begin errors++; $display("FAIL sat_pos_lin: got %0h expected 7f", dout_n); end
        step();
        for (int i = 0; i < 4; i++) put(32'd0, -32'sd1000);
        step();
        checks++; if (dout_r !== 8'h00) begin errors++; $display("FAIL sat_neg_relu: got %0h expected 0", dout_r); end
        checks++; if (dout_n !== 8'h80) begin errors++; $display("FAIL sat_neg_lin: got %0h expected 80", dout_n); end
        step();
    endtask

    task automatic test_back_to_back();
        put(32'd0, 32'd1);
        put(32'd0, 32'd2);
        put(32'd0, 32'd3);
        put(32'd0, 32'd4);
        // First product of group 2 lands in the S_DONE cycle of group 1.
        put(32'd100, 32'd5);
        checks++; if (vld_r !== 1'b1) begin errors++; $display("FAIL b2b_vld1: got %0b expected 1", vld_r); end
        checks++; if (dout_r !== 8'h03) begin errors++; $display("FAIL b2b_dout1: got %0h expected 3", dout_r); end
        checks++; if (busy_r !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %0b expected 1", busy_r); end
        put(32'd0, 32'd6);
        put(32'd0, 32'd7);
        put(32'd0, 32'd8);
        checks++; if (vld_r !== 1'b0) begin errors++; $display("FAIL b2b_vld_gap: got %0b expected 0", vld_r); end
        step();
        checks++; if (vld_r !== 1'b1) begin errors++; $display("FAIL b2b_vld2: got %0b expected 1", vld_r); end
        checks++; if (dout_r !== 8'h20) begin errors++; $display("FAIL b2b_dout2: got %0h expected 20", dout_r); end
        checks++; if (dout_n !== 8'h20) begin errors++; $display("FAIL b2b_dout2_lin: got %0h expected 20", dout_n); end
        step();
    endtask

    task automatic test_clear();
        put(32'd0, 32'd50);
        put(32'd0, 32'd50);
        // Clear together with a product: the product must be dropped.
        clear = 1'b1;
        put(32'd0, 32'd99);
        clear = 1'b0;
        checks++; if (busy_r !== 1'b0) begin errors++; $display("FAIL clr_busy: got %0b expected 0", busy_r); end
        step();
        step();
        checks++; if (vld_r !== 1'b0) begin errors++; $display("FAIL clr_no_out: got %0b expected 0", vld_r); end
        checks++; if (dout_r !== 8'h20) begin errors++; $display("FAIL clr_dout_hold: got %0h expected 20", dout_r); end
        put(32'd8, 32'd1);
        put(32'd0, 32'd1);
        put(32'd0, 32'd1);
        put(32'd0, 32'd1);
        step();
        checks++; if (vld_r !== 1'b1) begin errors++; $display("FAIL clr_fresh_vld: got %0b expected 1", vld_r); end
        checks++; if (dout_r !== 8'h03) begin errors++; $display("FAIL clr_fresh_dout: got %0h expected 3", dout_r); end
        step();
        for (int i = 0; i < 4; i++) put(32'd0, 32'd100);
        clear = 1'b1;
        step();
        clear = 1'b0;
        checks++; if (vld_r !== 1'b0) begin errors++; $display("FAIL clr_done_cancel: got %0b expected 0", vld_r); end
        checks++; if (dout_r !== 8'h03) begin errors++; $display("FAIL clr_done_hold: got %0h expected 3", dout_r); end
        step();
        checks++; if (vld_r !== 1'b0) begin errors++; $display("FAIL clr_done_late: got %0b expected 0", vld_r); end
    endtask

    task automatic test_overflow();
        put(32'h7FFF_FFFF, 32'd1);
        checks++; if (ovf_r !== 1'b1) begin errors++; $display("FAIL ovf_first: got %0b expected 1", ovf_r); end
        put(32'd0, 32'd0);
        put(32'd0, 32'd0);
        put(32'd0, 32'd0);
        step();
        checks++; if (dout_n !== 8'h80) begin errors++; $display("FAIL ovf_dout_lin: got %0h expected 80", dout_n); end
        checks++; if (dout_r !== 8'h00) begin errors++; $display("FAIL ovf_dout_relu: got %0h expected 0", dout_r); end
        step();
        checks++; if (ovf_r !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %0b expected 1", ovf_r); end
        put(32'd0, 32'd1);
        checks++; if (ovf_r !== 1'b0) begin errors++; $display("FAIL ovf_restart: got %0b expected 0", ovf_r); end
        put(32'd0, 32'h7FFF_FFFF);
        checks++; if (ovf_r !== 1'b1) begin errors++; $display("FAIL ovf_accum: got %0b expected 1", ovf_r); end
        clear = 1'b1;
        step();
        clear = 1'b0;
        checks++; if (ovf_r !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %0b expected 0", ovf_r); end
        put(32'h7FFF_FFFF, 32'd1);
        put(32'd0, 32'd0);
        put(32'd0, 32'd0);
        put(32'd0, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (dout_n !== 8'h00) begin errors++; $display("FAIL rst_done_dout: got %0h expected 0", dout_n); end
        checks++; if (ovf_n !== 1'b0) begin errors++; $display("FAIL rst_done_ovf: got %0b expected 0", ovf_n); end
        checks++; if (busy_n !== 1'b0) begin errors++; $display("FAIL rst_done_busy: got %0b expected 0", busy_n); end
        step();
        checks++; if (vld_n !== 1'b0) begin errors++; $display("FAIL rst_done_no_pulse: got %0b expected 0", vld_n); end
        put(32'd0, 32'd5);
        put(32'd0, 32'd6);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (busy_r !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %0b expected 0", busy_r); end
    endtask

    task automatic test_ce();
        put(32'd0, 32'd10);
        ce = 1'b0;
        put(32'd0, 32'd20);
        ce = 1'b1;
        put(32'd0, 32'd20);
        put(32'd0, 32'd30);
        put(32'd0, 32'd40);
        ce = 1'b0;
        step();
        checks++; if (vld_r !== 1'b0) begin errors++; $display("FAIL ce_hold_vld: got %0b expected 0", vld_r); end
        step();
        checks++; if (vld_r !== 1'b0) begin errors++; $display("FAIL ce_hold_vld2: got %0b expected 0", vld_r); end
        ce = 1'b1;
        step();
        checks++; if (vld_r !== 1'b1) begin errors++; $display("FAIL ce_resume_vld: got %0b expected 1", vld_r); end
        checks++; if (dout_r !== 8'h19) begin errors++; $display("FAIL ce_resume_dout: got %0h expected 19", dout_r); end
        ce = 1'b0;
        step();
        checks++; if (vld_r !== 1'b0) begin errors++; $display("FAIL ce_vld_drop: got %0b expected 0", vld_r); end
        ce = 1'b1;
    endtask

    initial begin
        rst             = 1'b1;
        ce              = 1'b1;
        clear           = 1'b0;
        product_din     = '0;
        product_din_vld = 1'b0;
        bias_din        = '0;
        test_reset();
        test_basic();
        test_negative();
        test_saturation();
        test_back_to_back();
        test_clear();
        test_overflow();
        test_ce();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
